// File: rtl/text_scan_sequencer.sv
// text_scan_sequencer: multi-pass line/column walker over the text-editor
// character BRAM. Each character is streamed with its line/column tags.
// Optional feature macro: SKIP_BLANK_EN (a zero character at column 0 ends
// that line early instead of being streamed).
module text_scan_sequencer #(
  parameter int CHAR_PER_LINE = 64,
  parameter int NUM_LINES     = 256,
  parameter int NUM_PASSES    = 2,
  parameter int READ_LATENCY  = 2,
  parameter int CHAR_WIDTH    = 8
) (
  input  logic                                           clk_in,
  input  logic                                           rst_in,
  input  logic                                           start_in,
  input  logic                                           line_done_in,
  input  logic                                           error_in,
  output logic [$clog2(CHAR_PER_LINE*NUM_LINES)-1:0]     mem_addr_out,
  input  logic [CHAR_WIDTH-1:0]                          mem_data_in,
  output logic                                           new_line_out,
  output logic                                           new_char_out,
  output logic [CHAR_WIDTH-1:0]                          char_out,
  output logic [$clog2(NUM_LINES)-1:0]                   line_out,
  output logic [$clog2(CHAR_PER_LINE)-1:0]               col_out,
  output logic [((NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1)-1:0] pass_out,
  output logic                                           busy_out,
  output logic                                           done_out,
  output logic                                           error_out
);

  localparam int AW = $clog2(CHAR_PER_LINE*NUM_LINES);
  localparam int LW = $clog2(NUM_LINES);
  localparam int CW = $clog2(CHAR_PER_LINE);
  localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam int DW = $clog2(READ_LATENCY+1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_NEW_LINE  = 3'd1;
  localparam logic [2:0] S_SEND      = 3'd2;
  localparam logic [2:0] S_DRAIN     = 3'd3;
  localparam logic [2:0] S_NEXT_PASS = 3'd4;
  localparam logic [2:0] S_ERR       = 3'd5;

  logic [2:0]              state;
  logic [LW-1:0]           line;
  logic [CW-1:0]           col;
  logic [PW-1:0]           pass;
  logic [DW-1:0]           dcnt;
  logic                    done_q;
  logic                    error_q;
  logic [READ_LATENCY-1:0] pvld;
  logic [LW-1:0]           pline [READ_LATENCY];
  logic [CW-1:0]           pcol  [READ_LATENCY];

  logic tail_vld;
  logic blank;
  logic in_stream;
  logic advance;
  logic last_line;
  logic last_pass;

  // Pipe tail status, blank-line detection and end-of-line decision
  always_comb begin
    tail_vld  = pvld[READ_LATENCY-1];
`ifdef SKIP_BLANK_EN
    blank     = tail_vld && (pcol[READ_LATENCY-1] == '0) && (mem_data_in == '0);
`else
    blank     = 1'b0;
`endif
    in_stream = (state == S_SEND) || (state == S_DRAIN);
    last_line = (line == LW'(NUM_LINES-1));
    last_pass = (pass == PW'(NUM_PASSES-1));
    // Early termination and natural drain completion share one advance path
    advance   = (in_stream && (line_done_in || blank)) ||
                ((state == S_DRAIN) && (dcnt == DW'(READ_LATENCY-1)));
  end

  // Output decode from registered state and pipe tail
  always_comb begin
    new_line_out = (state == S_NEW_LINE);
    new_char_out = tail_vld && !blank;
    char_out     = new_char_out ? mem_data_in : '0;
    col_out      = new_char_out ? pcol[READ_LATENCY-1] : '0;
    if (new_char_out)
      line_out = pline[READ_LATENCY-1];
    else if (state == S_NEW_LINE)
      line_out = line;
    else
      line_out = '0;
    mem_addr_out = (state == S_SEND) ? (AW'(line) * AW'(CHAR_PER_LINE) + AW'(col)) : '0;
    pass_out     = pass;
    busy_out     = (state == S_NEW_LINE) || (state == S_SEND) ||
                   (state == S_DRAIN) || (state == S_NEXT_PASS);
    done_out     = done_q;
    error_out    = error_q;
  end

  // Sequencer FSM, counters and read-tag pipe
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state   <= S_IDLE;
      line    <= '0;
      col     <= '0;
      pass    <= '0;
      dcnt    <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      pvld    <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        pline[i] <= '0;
        pcol[i]  <= '0;
      end
    end else begin
      done_q   <= 1'b0;
      pvld[0]  <= (state == S_SEND);
      pline[0] <= line;
      pcol[0]  <= col;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pvld[i]  <= pvld[i-1];
        pline[i] <= pline[i-1];
        pcol[i]  <= pcol[i-1];
      end

      if (start_in) begin
        state   <= S_NEW_LINE;
        line    <= '0;
        col     <= '0;
        pass    <= '0;
        error_q <= 1'b0;
        pvld    <= '0;
      end else if (error_in && (state != S_IDLE)) begin
        state   <= S_ERR;
        error_q <= 1'b1;
        pvld    <= '0;
      end else if (advance) begin
        // Flushing here also covers normal drain end: the pipe is already empty
        pvld <= '0;
        col  <= '0;
        if (!last_line) begin
          line  <= line + LW'(1);
          state <= S_NEW_LINE;
        end else if (!last_pass) begin
          state <= S_NEXT_PASS;
        end else begin
          state  <= S_IDLE;
          done_q <= 1'b1;
        end
      end else begin
        case (state)
          S_NEW_LINE: begin
            col   <= '0;
            state <= S_SEND;
          end
          S_SEND: begin
            if (col == CW'(CHAR_PER_LINE-1)) begin
              dcnt  <= '0;
              state <= S_DRAIN;
            end else begin
              col <= col + CW'(1);
            end
          end
          S_DRAIN: dcnt <= dcnt + DW'(1);
          S_NEXT_PASS: begin
            pass  <= pass + PW'(1);
            line  <= '0;
            col   <= '0;
            state <= S_NEW_LINE;
          end
          default: state <= state;
        endcase
      end
    end
  end

endmodule
